// File: rtl/riscv_multi_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller drives the master modport; the datapath side uses slave.
interface riscv_multi_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_we;
   logic       ir_we;
   logic       adr_src;
   logic       mem_we;
   logic       reg_we;
   logic [1:0] res_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] imm_src;
   logic [3:0] alu_ctrl;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
      output pc_we, ir_we, adr_src, mem_we, reg_we, res_src, alu_src_a, alu_src_b,
             imm_src, alu_ctrl, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
      input  pc_we, ir_we, adr_src, mem_we, reg_we, res_src, alu_src_a, alu_src_b,
             imm_src, alu_ctrl, illegal
   );
endinterface

// File: rtl/riscv_multi_ctrl.sv
// Control FSM for a RISC-V multicycle datapath with a shared memory port.
// Sequences fetch/decode/execute, stalls on mem_ready and counts retired instructions.
module riscv_multi_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   riscv_multi_ctrl_if.master  bus,
   output logic [3:0]          state,
   output logic [CNT_W-1:0]    instret
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StJal      = 4'd8,
      StAluWb    = 4'd9,
      StBranch   = 4'd10
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluAnd  = 4'd2;
   localparam logic [3:0] AluOr   = 4'd3;
   localparam logic [3:0] AluXor  = 4'd4;
   localparam logic [3:0] AluSlt  = 4'd5;
   localparam logic [3:0] AluSltu = 4'd6;
   localparam logic [3:0] AluSll  = 4'd7;
   localparam logic [3:0] AluSrl  = 4'd8;
   localparam logic [3:0] AluSra  = 4'd9;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic [3:0]       alu_dec;
   logic             retire;
   logic             pc_we_c, ir_we_c, mem_we_c, reg_we_c;
   logic             adr_src_c, illegal_c;
   logic [1:0]       res_src_c, alu_src_a_c, alu_src_b_c;
   logic [2:0]       imm_src_c;
   logic [3:0]       alu_ctrl_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StFetch;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Subtract only for R-type funct3=000 with funct7b5; shifts use funct7b5 for both R and I.
   always_comb begin
      alu_dec = AluAdd;
      unique case (bus.funct3)
         3'b000:  alu_dec = (state_q == StExecR && bus.funct7b5) ? AluSub : AluAdd;
         3'b001:  alu_dec = AluSll;
         3'b010:  alu_dec = AluSlt;
         3'b011:  alu_dec = AluSltu;
         3'b100:  alu_dec = AluXor;
         3'b101:  alu_dec = bus.funct7b5 ? AluSra : AluSrl;
         3'b110:  alu_dec = AluOr;
         default: alu_dec = AluAnd;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_we_c     = 1'b0;
      ir_we_c     = 1'b0;
      mem_we_c    = 1'b0;
      reg_we_c    = 1'b0;
      adr_src_c   = 1'b0;
      illegal_c   = 1'b0;
      res_src_c   = 2'd0;
      alu_src_a_c = 2'd0;
      alu_src_b_c = 2'd0;
      alu_ctrl_c  = AluAdd;
      retire      = 1'b0;

      case (bus.op)
         OpStore:  imm_src_c = 3'd1;
         OpBranch: imm_src_c = 3'd2;
         OpJal:    imm_src_c = 3'd3;
         default:  imm_src_c = 3'd0;
      endcase

      unique case (state_q)
         StFetch: begin
            alu_src_b_c = 2'd2;
            res_src_c   = 2'd2;
            ir_we_c     = bus.mem_ready;
            pc_we_c     = bus.mem_ready;
            if (bus.mem_ready) state_d = StDecode;
         end
         StDecode: begin
            alu_src_a_c = 2'd1;
            alu_src_b_c = 2'd1;
            case (bus.op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecR;
               OpIType:         state_d = StExecI;
               OpJal:           state_d = StJal;
               OpBranch: begin
                  if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) begin
                     state_d = StBranch;
                  end else begin
                     state_d   = StFetch;
                     illegal_c = 1'b1;
                  end
               end
               default: begin
                  state_d   = StFetch;
                  illegal_c = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            alu_src_a_c = 2'd2;
            alu_src_b_c = 2'd1;
            state_d     = (bus.op == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            adr_src_c = 1'b1;
            if (bus.mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            res_src_c = 2'd1;
            reg_we_c  = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            adr_src_c = 1'b1;
            mem_we_c  = 1'b1;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StExecR: begin
            alu_src_a_c = 2'd2;
            alu_ctrl_c  = alu_dec;
            state_d     = StAluWb;
         end
         StExecI: begin
            alu_src_a_c = 2'd2;
            alu_src_b_c = 2'd1;
            alu_ctrl_c  = alu_dec;
            state_d     = StAluWb;
         end
         StJal: begin
            alu_src_a_c = 2'd1;
            alu_src_b_c = 2'd2;
            pc_we_c     = 1'b1;
            state_d     = StAluWb;
         end
         StAluWb: begin
            reg_we_c = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
         end
         StBranch: begin
            alu_src_a_c = 2'd2;
            alu_ctrl_c  = AluSub;
            pc_we_c     = bus.zero ^ bus.funct3[0];
            retire      = 1'b1;
            state_d     = StFetch;
         end
         default: state_d = StFetch;
      endcase
   end

   // Write enables are gated by reset so an abandoned instruction writes nothing.
   assign bus.pc_we     = pc_we_c & rst;
   assign bus.ir_we     = ir_we_c & rst;
   assign bus.mem_we    = mem_we_c & rst;
   assign bus.reg_we    = reg_we_c & rst;
   assign bus.adr_src   = adr_src_c;
   assign bus.illegal   = illegal_c;
   assign bus.res_src   = res_src_c;
   assign bus.alu_src_a = alu_src_a_c;
   assign bus.alu_src_b = alu_src_b_c;
   assign bus.imm_src   = imm_src_c;
   assign bus.alu_ctrl  = alu_ctrl_c;
   assign state         = state_q;
   assign instret       = instret_q;

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Directed bench for riscv_multi_ctrl: walks each instruction class through the FSM
// with hand-computed expected outputs, including stalls, illegal opcodes and async reset.
module tb_riscv_multi_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  state;
   logic [31:0] instret;
   int          checks;
   int          errors;

   riscv_multi_ctrl_if bus ();

   riscv_multi_ctrl #(.CNT_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state   (state),
      .instret (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      bus.mem_ready = 1'b1;
      bus.op        = 7'b0010011;
      bus.funct3    = 3'b001;
      bus.funct7b5  = 1'b0;
      bus.zero      = 1'b0;
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_instret", instret, 0);
      chk("rst_ir_we", 32'(bus.ir_we), 0);
      chk("rst_pc_we", 32'(bus.pc_we), 0);

      // slli: FETCH -> DECODE -> EXECI -> ALUWB -> FETCH
      #11 rst = 1'b1;
      #1;
      chk("fetch_ir_we", 32'(bus.ir_we), 1);
      chk("fetch_pc_we", 32'(bus.pc_we), 1);
      chk("fetch_src_b", 32'(bus.alu_src_b), 2);
      chk("fetch_res_src", 32'(bus.res_src), 2);
      tick();
      chk("slli_decode", 32'(state), 1);
      chk("decode_src_a", 32'(bus.alu_src_a), 1);
      chk("decode_src_b", 32'(bus.alu_src_b), 1);
      tick();
      chk("slli_execi", 32'(state), 7);
      chk("slli_alu", 32'(bus.alu_ctrl), 7);
      chk("slli_src_b", 32'(bus.alu_src_b), 1);
      chk("slli_src_a", 32'(bus.alu_src_a), 2);
      tick();
      chk("slli_aluwb", 32'(state), 9);
      chk("slli_reg_we", 32'(bus.reg_we), 1);
      chk("slli_res_src", 32'(bus.res_src), 0);
      tick();
      chk("slli_fetch", 32'(state), 0);
      chk("slli_instret", instret, 1);

      // lw with a 3-cycle memory stall
      bus.op     = 7'b0000011;
      bus.funct3 = 3'b010;
      #1;
      chk("lw_imm_src", 32'(bus.imm_src), 0);
      tick();
      tick();
      chk("lw_memadr", 32'(state), 2);
      chk("lw_memadr_src_a", 32'(state == 4'd2 ? bus.alu_src_a : 2'd3), 2);
      tick();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lw_stall_state", 32'(state), 3);
         chk("lw_stall_adr_src", 32'(bus.adr_src), 1);
         if (i < 2) tick();
      end
      bus.mem_ready = 1'b1;
      tick();
      chk("lw_memwb", 32'(state), 4);
      chk("lw_reg_we", 32'(bus.reg_we), 1);
      chk("lw_res_src", 32'(bus.res_src), 1);
      tick();
      chk("lw_instret", instret, 2);

      // sw with a 2-cycle memory stall: mem_we held three cycles
      bus.op = 7'b0100011;
      #1;
      chk("sw_imm_src", 32'(bus.imm_src), 1);
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      chk("sw_state", 32'(state), 5);
      chk("sw_mem_we_1", 32'(bus.mem_we), 1);
      chk("sw_reg_we_1", 32'(bus.reg_we), 0);
      tick();
      chk("sw_mem_we_2", 32'(bus.mem_we), 1);
      chk("sw_reg_we_2", 32'(bus.reg_we), 0);
      tick();
      bus.mem_ready = 1'b1;
      #1;
      chk("sw_mem_we_3", 32'(bus.mem_we), 1);
      chk("sw_reg_we_3", 32'(bus.reg_we), 0);
      tick();
      chk("sw_fetch", 32'(state), 0);
      chk("sw_instret", instret, 3);

      // beq/bne with zero = 1/0
      bus.op = 7'b1100011;
      for (int i = 0; i < 4; i++) begin
         bus.funct3 = {2'b00, i[1]};
         bus.zero   = i[0];
         tick();
         chk("br_imm_src", 32'(bus.imm_src), 2);
         tick();
         chk("br_state", 32'(state), 10);
         chk("br_pc_we", 32'(bus.pc_we), 32'(i[0] ^ i[1]));
         chk("br_alu", 32'(bus.alu_ctrl), 1);
         tick();
         chk("br_instret", instret, 32'(4 + i));
      end

      // R-type sra, then sub via funct3 change while in EXECR
      bus.op       = 7'b0110011;
      bus.funct3   = 3'b101;
      bus.funct7b5 = 1'b1;
      tick();
      tick();
      chk("r_state", 32'(state), 6);
      chk("r_sra", 32'(bus.alu_ctrl), 9);
      chk("r_src_b", 32'(bus.alu_src_b), 0);
      bus.funct3 = 3'b000;
      #1;
      chk("r_sub", 32'(bus.alu_ctrl), 1);
      tick();
      tick();
      chk("r_instret", instret, 8);

      // I-type funct3=000 funct7b5=1 stays add
      bus.op = 7'b0010011;
      tick();
      tick();
      chk("i_state", 32'(state), 7);
      chk("i_add", 32'(bus.alu_ctrl), 0);
      tick();
      tick();
      chk("i_instret", instret, 9);

      // jal
      bus.op = 7'b1101111;
      tick();
      chk("jal_imm_src", 32'(bus.imm_src), 3);
      tick();
      chk("jal_state", 32'(state), 8);
      chk("jal_pc_we", 32'(bus.pc_we), 1);
      chk("jal_src_a", 32'(bus.alu_src_a), 1);
      chk("jal_src_b", 32'(bus.alu_src_b), 2);
      tick();
      chk("jal_aluwb", 32'(state), 9);
      tick();
      chk("jal_instret", instret, 10);

      // Illegal opcode
      bus.op = 7'b1111111;
      tick();
      chk("ill_state", 32'(state), 1);
      chk("ill_pulse", 32'(bus.illegal), 1);
      tick();
      chk("ill_back", 32'(state), 0);
      chk("ill_clear", 32'(bus.illegal), 0);
      chk("ill_instret", instret, 10);

      // Async reset in the middle of a store
      bus.op = 7'b0100011;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      chk("rst_sw_state", 32'(state), 5);
      chk("rst_sw_mem_we", 32'(bus.mem_we), 1);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_state", 32'(state), 0);
      chk("rst_mid_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mid_instret", instret, 0);
      chk("rst_mid_ir_we", 32'(bus.ir_we), 0);
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_multi_ctrl.md
Name: riscv_multi_ctrl

Overview:
- Control FSM that sequences the RISC-V multicycle datapath, which shares one memory port between instruction fetch and data access.
- Decodes the latched instruction fields and drives, per cycle, the PC/IR/register/memory write enables, mux selects, immediate format and ALU operation.
- Supports lw, sw, R-type ALU, I-type ALU (incl. slli/srli/srai), beq/bne and jal.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
op  in  7  instr[6:0] from the IR.
funct3  in  3  instr[14:12].
funct7b5  in  1  instr[30].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
pc_we  out  1  PC register write.
ir_we  out  1  IR and old-PC register write.
adr_src  out  1  memory address: 0 = PC, 1 = alu_out register.
mem_we  out  1  memory write.
reg_we  out  1  register file write.
res_src  out  2  result: 0 = alu_out reg, 1 = mem data reg, 2 = ALU result.
alu_src_a  out  2  0 = PC, 1 = old PC, 2 = reg_rd1.
alu_src_b  out  2  0 = reg_rd2, 1 = ext_imm, 2 = constant 4.
imm_src  out  3  0 = I, 1 = S, 2 = B, 3 = J.
alu_ctrl  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode or branch funct3.
state  out  4  current state, for debug.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, JAL 8, ALUWB 9, BRANCH 10.
- Reset (rst low, asynchronous):
  - state = FETCH, instret = 0.
  - While rst is low, pc_we, ir_we, mem_we and reg_we are forced to 0.
  - Reset mid-instruction abandons it with no further writes.
- Unlisted outputs are 0 in every state. Outputs depend on state plus op/funct3/funct7b5/zero/mem_ready.
- imm_src is decoded from op in all states: 0100011 → S, 1100011 → B, 1101111 → J, else I.
- FETCH:
  - adr_src=0, alu_src_a=0, alu_src_b=2, alu_ctrl=add, res_src=2.
  - ir_we = pc_we = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=1, alu_src_b=1, add (branch/jump target into alu_out). Next state by op:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1101111 → JAL.
  - 1100011 with funct3 ∈ {000, 001} → BRANCH.
  - Anything else → FETCH with illegal=1.
- MEMADR: alu_src_a=2, alu_src_b=1, add. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, res_src=0. Hold until mem_ready, then MEMWB.
- MEMWB: res_src=1, reg_we=1 → FETCH.
- MEMWRITE: adr_src=1, res_src=0, mem_we=1.
  - mem_we stays asserted until mem_ready.
  - Then → FETCH.
- EXECR: alu_src_a=2, alu_src_b=0, decoded alu_ctrl → ALUWB.
- EXECI: alu_src_a=2, alu_src_b=1, decoded alu_ctrl → ALUWB.
- JAL: alu_src_a=1, alu_src_b=2, add, res_src=0, pc_we=1 → ALUWB.
- ALUWB: res_src=0, reg_we=1 → FETCH.
- BRANCH: alu_src_a=2, alu_src_b=0, sub, res_src=0.
  - pc_we = zero XOR funct3[0].
  - → FETCH.
- ALU decode by funct3:
  - 000: add; sub only in EXECR with funct7b5=1.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: sra if funct7b5 else srl (applies to both R and I).
  - 110: or.
  - 111: and.
- Instruction latency, with mem_ready always 1:
  - lw 5 cycles.
  - sw, R, I, jal 4 cycles.
  - branch 3 cycles.
- instret increments by 1 (wrapping at 2^CNT_W) on the clock edge leaving MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH.
- instret does not increment on an illegal opcode.

Test Plan:
- Reset release, mem_ready=1, op=0010011 funct3=001 (slli):
  - States 0→1→7→9→0.
  - EXECI shows alu_ctrl=7, alu_src_b=1.
  - ALUWB shows reg_we=1, res_src=0.
  - instret=1.
- op=0000011 (lw), mem_ready held 0 for 3 cycles in MEMREAD:
  - State stays 3 with adr_src=1 for those cycles.
  - Then MEMWB with reg_we=1, res_src=1.
  - instret+1.
- op=0100011 (sw), mem_ready low 2 cycles:
  - mem_we=1 for 3 cycles.
  - reg_we never asserted.
  - imm_src=1.
- op=1100011 funct3=000:
  - zero=1 → BRANCH pc_we=1.
  - zero=0 → pc_we=0.
  - funct3=001 inverts both cases.
  - alu_ctrl=1 in both.
- op=0110011 funct3=101 funct7b5=1 → alu_ctrl=9; funct3=000 funct7b5=1 → alu_ctrl=1; same funct3=000 on op=0010011 → alu_ctrl=0.
- op=1111111 → illegal=1 for one cycle, back to FETCH, instret unchanged. Separately, rst pulled low in MEMWRITE → immediate state=0, mem_we=0, instret=0.
